// File: rtl/ui_nibble_debounce.sv
// Switch-nibble input conditioner: two-flop synchronizer plus per-channel
// stability counter, with registered rise/fall event pulses.
module ui_nibble_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             any_change_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic             anyChange_q;

  // A channel accepts its synchronized level only after it has differed from
  // the stable level for DEBOUNCE_CYCLES consecutive edges; any return clears.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      anyChange_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= din_i;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      anyChange_q <= |(rise_d | fall_d);
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign dout_o       = stable_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign any_change_o = anyChange_q;

endmodule

// File: tb/tb_ui_nibble_debounce.sv
// Self-checking bench: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance
// compared every cycle against a history-window reference model.
module tb_ui_nibble_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dinA, dinB;
  logic [3:0] doutA, riseA, fallA;
  logic [3:0] doutB, riseB, fallB;
  logic       anyA, anyB;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ui_nibble_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dutA (
    .clk_i(clk), .rst_i(rst), .din_i(dinA),
    .dout_o(doutA), .rise_o(riseA), .fall_o(fallA), .any_change_o(anyA)
  );

  ui_nibble_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(1)) dutB (
    .clk_i(clk), .rst_i(rst), .din_i(dinB),
    .dout_o(doutB), .rise_o(riseB), .fall_o(fallB), .any_change_o(anyB)
  );

  // Reference model: the level seen by the counter at edge n is the input
  // recorded at edge n-2; a channel flips once its last D seen values all
  // disagree with the accepted level.
  localparam int HIST = 8192;
  int         dc [2] = '{4, 1};
  logic [3:0] rec [2][HIST];
  logic [3:0] mStable [2];
  logic [3:0] mRise [2];
  logic [3:0] mFall [2];
  int         edgeNum;

  always @(posedge clk or posedge rst) begin
    int   idx;
    logic v;
    logic settled;
    if (rst) begin
      edgeNum = 0;
      for (int k = 0; k < 2; k++) begin
        mStable[k] = 4'h0;
        mRise[k]   = 4'h0;
        mFall[k]   = 4'h0;
      end
    end else begin
      if (edgeNum < HIST) begin
        rec[0][edgeNum] = dinA;
        rec[1][edgeNum] = dinB;
      end
      for (int k = 0; k < 2; k++) begin
        mRise[k] = 4'h0;
        mFall[k] = 4'h0;
        for (int c = 0; c < 4; c++) begin
          settled = 1'b1;
          for (int j = 0; j < dc[k]; j++) begin
            idx = edgeNum - 2 - j;
            v   = (idx < 0 || idx >= HIST) ? 1'b0 : rec[k][idx][c];
            if (v == mStable[k][c]) settled = 1'b0;
          end
          if (settled) begin
            mStable[k][c] = ~mStable[k][c];
            if (mStable[k][c]) mRise[k][c] = 1'b1;
            else               mFall[k][c] = 1'b1;
          end
        end
      end
      edgeNum++;
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  logic modelCheckOn = 1'b0;

  always @(negedge clk) begin
    if (modelCheckOn && !rst) begin
      checkOutput("A.dout", doutA, mStable[0]);
      checkOutput("A.rise", riseA, mRise[0]);
      checkOutput("A.fall", fallA, mFall[0]);
      checkOutput("A.any",  {3'b0, anyA}, {3'b0, |(mRise[0] | mFall[0])});
      checkOutput("B.dout", doutB, mStable[1]);
      checkOutput("B.rise", riseB, mRise[1]);
      checkOutput("B.fall", fallB, mFall[1]);
      checkOutput("B.any",  {3'b0, anyB}, {3'b0, |(mRise[1] | mFall[1])});
    end
  end

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input int cycles);
    dinA = a;
    dinB = b;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic asyncResetCheck();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst.doutA", doutA, 4'h0);
    checkOutput("rst.riseA", riseA, 4'h0);
    checkOutput("rst.anyA",  {3'b0, anyA}, 4'h0);
    checkOutput("rst.doutB", doutB, 4'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int holdA [4];
  int holdB [4];

  initial begin
    rst  = 1'b0;
    dinA = 4'h0;
    dinB = 4'h0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    modelCheckOn = 1'b1;
    applyStimulus(4'h0, 4'h0, 4);
    checkOutput("idle.doutA", doutA, 4'h0);

    // Reset with all inputs high: outputs clear at once, rise at 6th edge
    applyStimulus(4'hF, 4'h0, 10);
    checkOutput("pre.doutA", doutA, 4'hF);
    asyncResetCheck();
    repeat (5) @(negedge clk);
    checkOutput("rel.E4.doutA", doutA, 4'h0);
    @(negedge clk);
    checkOutput("rel.E5.doutA", doutA, 4'hF);
    checkOutput("rel.E5.riseA", riseA, 4'hF);
    checkOutput("rel.E5.anyA",  {3'b0, anyA}, 4'h1);
    @(negedge clk);
    checkOutput("rel.E6.riseA", riseA, 4'h0);
    applyStimulus(4'h0, 4'h0, 12);

    // Bounce rejection on channel 1
    for (int p = 0; p < 4; p++) begin
      dinA = (p % 2 == 0) ? 4'b0010 : 4'b0000;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checkOutput("bounce.dout1", {3'b0, doutA[1]}, 4'h0);
        checkOutput("bounce.any",   {3'b0, anyA}, 4'h0);
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("bounce.tail.any", {3'b0, anyA}, 4'h0);
    end

    // Glitch then settle on channel 2
    applyStimulus(4'b0100, 4'h0, 2);
    applyStimulus(4'b0000, 4'h0, 1);
    applyStimulus(4'b0100, 4'h0, 5);
    checkOutput("settle.E4.rise", riseA, 4'h0);
    @(negedge clk);
    checkOutput("settle.E5.rise", riseA, 4'b0100);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("settle.once", riseA, 4'h0);
    end
    applyStimulus(4'h0, 4'h0, 12);

    // Simultaneous channels
    applyStimulus(4'b1010, 4'h0, 6);
    checkOutput("simul.rise", riseA, 4'b1010);
    checkOutput("simul.any",  {3'b0, anyA}, 4'h1);
    applyStimulus(4'b1010, 4'h0, 6);
    applyStimulus(4'b0101, 4'h0, 6);
    checkOutput("swap.fall", fallA, 4'b1010);
    checkOutput("swap.rise", riseA, 4'b0101);
    checkOutput("swap.dout", doutA, 4'b0101);
    @(negedge clk);
    checkOutput("swap.any.clear", {3'b0, anyA}, 4'h0);
    applyStimulus(4'h0, 4'h0, 12);

    // One-cycle pulse through the DEBOUNCE_CYCLES=1 instance
    applyStimulus(4'h0, 4'b1000, 1);
    applyStimulus(4'h0, 4'b0000, 2);
    checkOutput("d1.E2.dout", doutB, 4'b1000);
    checkOutput("d1.E2.rise", riseB, 4'b1000);
    @(negedge clk);
    checkOutput("d1.E3.dout", doutB, 4'b0000);
    checkOutput("d1.E3.fall", fallB, 4'b1000);
    checkOutput("d1.E3.rise", riseB, 4'b0000);
    applyStimulus(4'h0, 4'h0, 4);

    // Randomized bouncy inputs with one mid-stream reset
    for (int c = 0; c < 4; c++) begin
      holdA[c] = 1;
      holdB[c] = 1;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 1000) asyncResetCheck();
      for (int c = 0; c < 4; c++) begin
        holdA[c]--;
        if (holdA[c] <= 0) begin
          dinA[c]  = ~dinA[c];
          holdA[c] = $urandom_range(1, 9);
        end
        holdB[c]--;
        if (holdB[c] <= 0) begin
          dinB[c]  = ~dinB[c];
          holdB[c] = $urandom_range(1, 4);
        end
      end
      @(negedge clk);
    end

    modelCheckOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ui_nibble_debounce.md
# ui_nibble_debounce

Input conditioner for the 4-bit switch nibble that feeds the nibble-inverter tile. Each raw pad bit passes through a 2-flop synchronizer and then a per-channel stability counter. The stable level is presented to the inverter, with one-cycle rise/fall event pulses for downstream logic. The block removes metastability and contact bounce so that the inverter output nibble only changes on clean, settled input transitions.

## Interface
- `WIDTH`, 4: number of independent channels.
- `DEBOUNCE_CYCLES`, 4: consecutive clk cycles a synchronized level must persist before acceptance; legal range 1..65535.
- `clk`  in  1  single clock for all state.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  raw asynchronous inputs (`ui_in[3:0]` in the tile).
- `dout`  out  WIDTH  debounced stable levels; drives the inverter inputs.
- `rise`  out  WIDTH  one-cycle pulse per channel when `dout` goes 0->1.
- `fall`  out  WIDTH  one-cycle pulse per channel when `dout` goes 1->0.
- `any_change`  out  1  OR-reduction of `rise|fall`; same cycle as the pulses.

## Operation
- Per channel, state is:
  - `s1`, `s2`: synchronizer flops.
  - `stable`: the accepted level; drives `dout`.
  - `cnt`: counter, width `max(1, clog2(DEBOUNCE_CYCLES))`.
  - registered `rise`/`fall` bits.
- Every clk edge: `s1 <= din`, `s2 <= s1`.
- Counter/acceptance, evaluated every edge:
  - `s2 == stable`: `cnt <= 0`; no event.
  - `s2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s2`, `cnt <= 0`. Pulse `rise` if `s2 == 1`, `fall` if `s2 == 0`.
  - `s2 != stable` otherwise: `cnt <= cnt+1`.
- Channels are fully independent. Several channels may fire in the same cycle, and `any_change` is then a single 1.
- A bounce, i.e. `s2` returning to `stable` before the count completes, clears `cnt`. No event and no `dout` change.
- The counter never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.
- `rise` and `fall` for one channel are never high together.
- `DEBOUNCE_CYCLES == 1`: a level is accepted on the first edge that sees `s2 != stable`.

## Timing
- Reset (async assert, sync release): `s1`, `s2`, `stable`, `cnt`, `rise`, `fall`, `dout` and `any_change` all 0.
- Reset mid-count discards progress. A channel whose `din` is held high through reset release fires `rise` as if newly pressed.
- Latency: take `din` changed and held before edge E0.
  - `s2` holds the new value after E1.
  - `dout` and the event pulse update at edge E(DEBOUNCE_CYCLES+1), i.e. DEBOUNCE_CYCLES+2 edges after the change.
- `rise`, `fall` and `any_change` are registered outputs. Each is high for exactly one cycle, coincident with the first cycle of the new `dout` value.
- Minimum accepted pulse width on `din` is DEBOUNCE_CYCLES cycles at the `s2` stage. Shorter excursions are fully rejected.
- All outputs are flop-driven; no combinational path from `din`.

## Test plan
- **Reset:** bench uses DEBOUNCE_CYCLES=4. Assert `rst` asynchronously mid-cycle with `din=4'hF` -> all outputs 0 immediately. Release -> `dout=4'hF` and `rise=4'hF` / `any_change=1` for one cycle at the 6th edge after release.
- **Clean press:** `din[0]` 0->1 held before E0 -> `dout[0]=1` and `rise[0]=1` after E5 (one cycle only). Release -> `fall[0]` after E5 of the release, `dout[0]=0`.
- **Bounce rejection:** `din[1]` toggles 1,0,1,0 with 3-cycle high phases, then stays 0 -> `dout[1]`, `rise[1]` and `any_change` stay 0 throughout.
- **Bounce then settle:** `din[2]` has a 2-cycle high glitch, 1 low, then stays high -> `rise[2]` fires exactly once, 6 edges after the final rising edge.
- **Simultaneous channels:** `din` 0->`4'b1010` at once -> `rise=4'b1010` and `any_change=1` in the same single cycle. Then `din=4'b0101` -> the same cycle shows `fall=4'b1010` and `rise=4'b0101`, with `any_change` high for that one cycle.
- **DEBOUNCE_CYCLES=1 build:** a 1-cycle `din[3]` pulse produces a `dout[3]` high for exactly one cycle, `rise[3]` then `fall[3]` on consecutive cycles; total latency 3 edges.
